ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 6000: clock-low hold before request-to-send (120 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000: maximum gap between device falling edges (15 ms).
REQ-003 SHALL have port clock  in  1  system clock (50 MHz); the block uses this one clock only.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tx_data  in  8  command byte to send to the keyboard.
REQ-006 SHALL have port tx_valid  in  1  send request.
REQ-007 SHALL have port tx_ready  out  1  block idle; accepts a request.
REQ-008 SHALL have port tx_done  out  1  one-cycle pulse: byte sent and acknowledged.
REQ-009 SHALL have port tx_error  out  1  one-cycle pulse: timeout or missing ack.
REQ-010 SHALL have port rx_inhibit  out  1  high when not IDLE; receive path discards bytes while high.
REQ-011 SHALL have port ps2_clk_in  in  1  raw PS/2 clock line level.
REQ-012 SHALL have port ps2_dat_in  in  1  raw PS/2 data line level.
REQ-013 SHALL have port ps2_clk_drive_low  out  1  open-drain pull-down enable for PS/2 clock.
REQ-014 SHALL have port ps2_dat_drive_low  out  1  open-drain pull-down enable for PS/2 data.

Function
REQ-015 SHALL synchronise ps2_clk_in and ps2_dat_in through 2 flops each; a falling edge (fe) is synced clock 1 then 0.
REQ-016 SHALL implement the states IDLE, INHIBIT, REQ, XFER, WAIT_IDLE.
REQ-017 IDLE: tx_ready=1; both drives 0; on tx_valid&tx_ready, capture tx_data, compute odd parity (~^tx_data), go to INHIBIT.
REQ-018 SHALL ignore tx_valid outside IDLE; the captured byte is not altered mid-transfer.
REQ-019 INHIBIT: ps2_clk_drive_low=1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
REQ-020 REQ: both drives=1 for 1 cycle (start bit), then go to XFER with clk drive released and data drive kept at 1.
REQ-021 XFER: a 4-bit edge counter n (0..10) counts fe; fe 1-8 set ps2_dat_drive_low=~bit[n-1] (LSB first); fe 9 sets it to ~parity; fe 10 releases data (stop).
REQ-022 At fe 11, synced data=0 SHALL go to WAIT_IDLE; synced data=1 SHALL pulse tx_error and go to IDLE.
REQ-023 WAIT_IDLE: go to IDLE when both synced lines are 1; tx_done pulses during the first IDLE cycle.
REQ-024 SHALL reset a timeout counter on entering REQ and on every fe.
REQ-025 In XFER or WAIT_IDLE, a counter value of TIMEOUT_CYCLES SHALL release both drives, pulse tx_error, and go to IDLE.
REQ-026 tx_done and tx_error SHALL never be asserted in the same cycle.
REQ-027 All outputs SHALL be registered.
REQ-028 rx_inhibit SHALL equal the inverse of tx_ready.

Reset
REQ-029 resetn=0 SHALL force, asynchronously: state IDLE, tx_ready=1, tx_done=0, tx_error=0, rx_inhibit=0, both drives 0 (lines released), and all counters and sync flops to 0/idle.
REQ-030 Reset in the middle of a transfer SHALL abandon the byte without a tx_done or tx_error pulse.

Structure
REQ-031 State encodings and default timing constants SHALL reside in the shared include ps2_defs.vh, used with the receive path.
REQ-032 SHALL use one sub-module, ps2_line_sync (2-flop synchroniser plus fe detect), instantiated for the clock line and the data line.

Verification
REQ-033 Send tx_data=0xED with a modelled device -> clock held low 6000 cycles, data bits 1,0,1,1,0,1,1,1, parity 1, stop released, device ack -> tx_done pulse once.
REQ-034 Send 0xF4 -> parity bit 0; tx_ready=0 and rx_inhibit=1 from acceptance until the IDLE return.
REQ-035 Device does not pull data low at fe 11 -> tx_error pulse, no tx_done, both drives 0.
REQ-036 Device stops clocking after fe 4 -> tx_error exactly TIMEOUT_CYCLES cycles after fe 4, lines released.
REQ-037 tx_valid held high through a transfer with tx_data changed to 0x00 mid-byte -> transmitted bits still match the captured byte; next transfer starts only after IDLE.
REQ-038 resetn asserted during INHIBIT and during XFER -> drives go to 0 immediately, no pulses, tx_ready=1 after release.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: controller state encoding, default timing constants
// and the frame payload, used by the host transmit path and the receive path.
package ps2_host_tx_pkg;

  localparam int unsigned INHIBIT_CYCLES_DEF = 6000;    // 120 us at 50 MHz
  localparam int unsigned TIMEOUT_CYCLES_DEF = 750000;  // 15 ms at 50 MHz

  localparam int unsigned EDGE_W = 4;
  // Device falling edges 1..10 carry data, parity and stop; edge 11 is the ack
  localparam logic [EDGE_W-1:0] LAST_DATA_EDGE = 4'd8;
  localparam logic [EDGE_W-1:0] PARITY_EDGE    = 4'd9;
  localparam logic [EDGE_W-1:0] STOP_EDGE      = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_XFER      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       parity;
  } ps2_frame_t;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one PS/2 line with registered falling-edge detect.
module ps2_line_sync (
  input  logic clock,
  input  logic resetn,
  input  logic line_i,
  output logic sync_o,
  output logic fe_o
);

  logic meta_q;
  logic sync_q;
  logic fe_q;

  // Lines idle high, so the flops reset to 1 and no edge is seen out of reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      fe_q   <= 1'b0;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      fe_q   <= sync_q & ~meta_q;
    end
  end

  assign sync_o = sync_q;
  assign fe_o   = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clocked-out frame
// with odd parity, ack check and inter-edge timeout.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low
);

  localparam int unsigned ICNT_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ICNT_W-1:0] ICNT_LAST  = ICNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_LIMIT = TCNT_W'(TIMEOUT_CYCLES);

  logic clk_sync;
  logic clk_fe;
  logic dat_sync;
  logic dat_fe_unused;

  ps2_line_sync u_clk_sync (
    .clock  (clock),
    .resetn (resetn),
    .line_i (ps2_clk_in),
    .sync_o (clk_sync),
    .fe_o   (clk_fe)
  );

  ps2_line_sync u_dat_sync (
    .clock  (clock),
    .resetn (resetn),
    .line_i (ps2_dat_in),
    .sync_o (dat_sync),
    .fe_o   (dat_fe_unused)
  );

  ps2_state_e        state_q,  state_d;
  ps2_frame_t        frame_q,  frame_d;
  logic [ICNT_W-1:0] icnt_q,   icnt_d;
  logic [TCNT_W-1:0] tcnt_q,   tcnt_d;
  logic [EDGE_W-1:0] edge_q,   edge_d;
  logic              clk_drv_q, clk_drv_d;
  logic              dat_drv_q, dat_drv_d;
  logic              ready_q,  ready_d;
  logic              inhib_q,  inhib_d;
  logic              done_q,   done_d;
  logic              error_q,  error_d;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    icnt_d    = icnt_q;
    tcnt_d    = tcnt_q;
    edge_d    = edge_q;
    clk_drv_d = clk_drv_q;
    dat_drv_d = dat_drv_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid && ready_q) begin
          frame_d.data   = tx_data;
          frame_d.parity = odd_parity(tx_data);
          icnt_d         = '0;
          clk_drv_d      = 1'b1;
          state_d        = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (icnt_q == ICNT_LAST) begin
          dat_drv_d = 1'b1;
          tcnt_d    = '0;
          state_d   = ST_REQ;
        end else begin
          icnt_d = icnt_q + ICNT_W'(1);
        end
      end

      // Start bit is on the data line; hand the clock back to the device
      ST_REQ: begin
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b1;
        edge_d    = '0;
        tcnt_d    = tcnt_q + TCNT_W'(1);
        state_d   = ST_XFER;
      end

      ST_XFER: begin
        if (clk_fe) begin
          tcnt_d = '0;
          if (edge_q == STOP_EDGE) begin
            if (!dat_sync) begin
              state_d = ST_WAIT_IDLE;
            end else begin
              error_d = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            edge_d = edge_q + EDGE_W'(1);
            if (edge_q < LAST_DATA_EDGE) begin
              dat_drv_d = ~frame_q.data[edge_q[2:0]];
            end else if (edge_q + EDGE_W'(1) == PARITY_EDGE) begin
              dat_drv_d = ~frame_q.parity;
            end else begin
              dat_drv_d = 1'b0;
            end
          end
        end else if (tcnt_q == TCNT_LIMIT) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_fe) begin
          tcnt_d = '0;
        end else if (clk_sync && dat_sync) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tcnt_q == TCNT_LIMIT) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Lines are always released whenever the controller rests in IDLE
    if (state_d == ST_IDLE) begin
      clk_drv_d = 1'b0;
      dat_drv_d = 1'b0;
    end

    ready_d = (state_d == ST_IDLE);
    inhib_d = ~ready_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      icnt_q    <= '0;
      tcnt_q    <= '0;
      edge_q    <= '0;
      clk_drv_q <= 1'b0;
      dat_drv_q <= 1'b0;
      ready_q   <= 1'b1;
      inhib_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      icnt_q    <= icnt_d;
      tcnt_q    <= tcnt_d;
      edge_q    <= edge_d;
      clk_drv_q <= clk_drv_d;
      dat_drv_q <= dat_drv_d;
      ready_q   <= ready_d;
      inhib_q   <= inhib_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign tx_ready          = ready_q;
  assign rx_inhibit        = inhib_q;
  assign tx_done           = done_q;
  assign tx_error          = error_q;
  assign ps2_clk_drive_low = clk_drv_q;
  assign ps2_dat_drive_low = dat_drv_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on open-drain lines plus a
// frame reference built from the byte value and its count of ones.
module tb_ps2_host_tx;

  localparam int INH  = 6000;
  localparam int TMO  = 300;
  localparam int HALF = 15;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, rx_inhibit;
  logic       ps2_clk_drive_low, ps2_dat_drive_low;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_line, ps2_dat_line;

  assign ps2_clk_line = ~(ps2_clk_drive_low | dev_clk_low);
  assign ps2_dat_line = ~(ps2_dat_drive_low | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock             (clock),
    .resetn            (resetn),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .tx_done           (tx_done),
    .tx_error          (tx_error),
    .rx_inhibit        (rx_inhibit),
    .ps2_clk_in        (ps2_clk_line),
    .ps2_dat_in        (ps2_dat_line),
    .ps2_clk_drive_low (ps2_clk_drive_low),
    .ps2_dat_drive_low (ps2_dat_drive_low)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, viol = 0, busy_ready = 0, err_cyc = 0;
  bit busy = 1'b0;
  int tests = 0, fails = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Continuous properties and pulse bookkeeping
  always @(negedge clock) begin
    if (rx_inhibit !== ~tx_ready) viol <= viol + 1;
    if (tx_done && tx_error) viol <= viol + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (busy && tx_ready) busy_ready <= busy_ready + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Device-side view: 8 data bits LSB first, odd parity, stop bit 1
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    int ones;
    ones = $countones(b);
    return {1'b1, (ones % 2 == 0), b};
  endfunction

  task automatic accept(input logic [7:0] b);
    @(negedge clock);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  // Waits for the host request-to-send, then clocks the frame and optionally acks
  task automatic device_xfer(input bit ack, input int stop_after,
                             output logic [9:0] bits, output int fe4_cyc, output bit started);
    int w;
    bits = '0;
    fe4_cyc = 0;
    started = 1'b0;
    w = 0;
    while (!(ps2_clk_drive_low === 1'b0 && ps2_dat_drive_low === 1'b1) && w < INH + 200) begin
      @(negedge clock);
      w++;
    end
    if (!(ps2_clk_drive_low === 1'b0 && ps2_dat_drive_low === 1'b1)) return;
    started = 1'b1;
    repeat (10) @(negedge clock);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) begin
        dev_dat_low = 1'b1;
        repeat (5) @(negedge clock);
      end
      dev_clk_low = 1'b1;
      if (k == 4) fe4_cyc = cyc;
      repeat (HALF) @(negedge clock);
      if (k <= 10) bits[k-1] = ps2_dat_line;
      dev_clk_low = 1'b0;
      if (k == stop_after) return;
      repeat (HALF) @(negedge clock);
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_outcome(input int d0, input int e0);
    int w;
    w = 0;
    while ((done_cnt + err_cnt) == (d0 + e0) && w < TMO + 200) begin
      @(negedge clock);
      w++;
    end
    repeat (3) @(negedge clock);
  endtask

  logic [9:0] bits;
  int         fe4_cyc, n, d0, e0;
  bit         started, ack;
  logic [7:0] b;

  initial begin
    // Reset values while resetn is low
    repeat (3) @(negedge clock);
    check("rst_ready", tx_ready, 1);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    check("rst_inhibit", rx_inhibit, 0);
    check("rst_drives", {ps2_clk_drive_low, ps2_dat_drive_low}, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    check("post_rst_ready", tx_ready, 1);

    // 0xED with inhibit and request-to-send timing
    d0 = done_cnt; e0 = err_cnt;
    accept(8'hED);
    check("ed_ready_low", tx_ready, 0);
    n = 0;
    while (ps2_clk_drive_low && !ps2_dat_drive_low && n < INH + 10) begin
      n++;
      @(negedge clock);
    end
    check("ed_inhibit_len", n, INH);
    check("ed_req_drives", {ps2_clk_drive_low, ps2_dat_drive_low}, 2'b11);
    @(negedge clock);
    check("ed_xfer_drives", {ps2_clk_drive_low, ps2_dat_drive_low}, 2'b01);
    device_xfer(1'b1, 0, bits, fe4_cyc, started);
    check("ed_started", started, 1);
    wait_outcome(d0, e0);
    check("ed_frame", bits, ref_frame(8'hED));
    check("ed_frame_lit", bits, 10'b1_1_11101101);
    check("ed_done", done_cnt - d0, 1);
    check("ed_error", err_cnt - e0, 0);
    check("ed_drives_idle", {ps2_clk_drive_low, ps2_dat_drive_low}, 0);

    // 0xF4: parity 0, never ready while busy
    d0 = done_cnt; e0 = err_cnt;
    accept(8'hF4);
    busy = 1'b1;
    check("f4_inhibit_hi", rx_inhibit, 1);
    device_xfer(1'b1, 0, bits, fe4_cyc, started);
    busy = 1'b0;
    wait_outcome(d0, e0);
    check("f4_parity", bits[8], 0);
    check("f4_frame", bits, ref_frame(8'hF4));
    check("f4_busy_ready", busy_ready, 0);
    check("f4_done", done_cnt - d0, 1);
    check("f4_ready_back", {tx_ready, rx_inhibit}, 2'b10);

    // Missing ack at edge 11
    d0 = done_cnt; e0 = err_cnt;
    accept(8'h96);
    device_xfer(1'b0, 0, bits, fe4_cyc, started);
    wait_outcome(d0, e0);
    check("noack_frame", bits, ref_frame(8'h96));
    check("noack_error", err_cnt - e0, 1);
    check("noack_done", done_cnt - d0, 0);
    check("noack_drives", {ps2_clk_drive_low, ps2_dat_drive_low}, 0);

    // Device stops after edge 4: 2 sync stages, 1 cycle counter restart,
    // TIMEOUT_CYCLES counts, 1 output register
    d0 = done_cnt; e0 = err_cnt;
    accept(8'h5A);
    device_xfer(1'b1, 4, bits, fe4_cyc, started);
    wait_outcome(d0, e0);
    check("tmo_bits", bits[3:0], 4'hA);
    check("tmo_error", err_cnt - e0, 1);
    check("tmo_done", done_cnt - d0, 0);
    check("tmo_latency", err_cyc - fe4_cyc, TMO + 4);
    check("tmo_drives", {ps2_clk_drive_low, ps2_dat_drive_low}, 0);

    // tx_valid held, data changed mid-byte
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clock);
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    @(negedge clock);
    fork
      device_xfer(1'b1, 0, bits, fe4_cyc, started);
      begin
        repeat (INH + 100) @(negedge clock);
        tx_data = 8'h00;
      end
    join
    wait_outcome(d0, e0);
    check("hold_frame", bits, ref_frame(8'h3C));
    check("hold_done_once", done_cnt - d0, 1);
    check("hold_restart", tx_ready, 0);
    tx_valid = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    device_xfer(1'b1, 0, bits, fe4_cyc, started);
    wait_outcome(d0, e0);
    check("hold_second_frame", bits, ref_frame(8'h00));
    check("hold_second_done", done_cnt - d0, 1);

    // Randomised bytes and ack behaviour
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(255));
      ack = ($urandom_range(9) < 7);
      d0 = done_cnt; e0 = err_cnt;
      accept(b);
      device_xfer(ack, 0, bits, fe4_cyc, started);
      wait_outcome(d0, e0);
      check($sformatf("rnd%0d_frame_%02h", i, b), bits, ref_frame(b));
      check($sformatf("rnd%0d_outcome", i), {done_cnt - d0, err_cnt - e0},
            ack ? {32'd1, 32'd0} : {32'd0, 32'd1});
    end

    // Reset during INHIBIT
    d0 = done_cnt; e0 = err_cnt;
    accept(8'h55);
    repeat (200) @(negedge clock);
    check("rsti_pre_clk", ps2_clk_drive_low, 1);
    resetn = 1'b0;
    #1;
    check("rsti_drives", {ps2_clk_drive_low, ps2_dat_drive_low}, 0);
    check("rsti_ready", tx_ready, 1);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (INH + 50) @(negedge clock);
    check("rsti_pulses", {done_cnt - d0, err_cnt - e0}, 0);
    check("rsti_ready_after", tx_ready, 1);

    // Reset during XFER, after edge 5 drives bit 4 (0) low
    d0 = done_cnt; e0 = err_cnt;
    accept(8'h0F);
    device_xfer(1'b1, 5, bits, fe4_cyc, started);
    check("rstx_pre_dat", ps2_dat_drive_low, 1);
    resetn = 1'b0;
    #1;
    check("rstx_drives", {ps2_clk_drive_low, ps2_dat_drive_low}, 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (TMO + 50) @(negedge clock);
    check("rstx_pulses", {done_cnt - d0, err_cnt - e0}, 0);
    check("rstx_ready_after", tx_ready, 1);

    check("monitor_props", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
